// File: rtl/nv_reset_seq_pkg.sv
// Shared types and default timing constants for the per-domain reset sequencer.
package nv_reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_QUIESCE = 2'd3
  } seq_state_e;

  localparam int DEF_NUM_DOM     = 4;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_ASSERT_HOLD = 8;
  localparam int DEF_REL_GAP     = 16;
  localparam int DEF_QTO         = 255;

endpackage

// File: rtl/nv_reset_seq_cnt.sv
// Loadable up-counter with clear and terminal-count compare; shared by the
// hold, release-gap and quiesce-timeout phases of nv_reset_seq.
module nv_reset_seq_cnt
  import nv_reset_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] tc_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;

  // Clear wins over load, load wins over increment.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (inc_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/nv_reset_seq.sv
// Per-domain reset sequencer with soft-reset req/ack handshake.
// Optional quiesce timeout enabled by defining NV_RESET_SEQ_QTO_EN.
module nv_reset_seq
  import nv_reset_seq_pkg::*;
#(
  parameter int NUM_DOM     = DEF_NUM_DOM,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int ASSERT_HOLD = DEF_ASSERT_HOLD,
  parameter int REL_GAP     = DEF_REL_GAP,
  parameter int QTO         = DEF_QTO
) (
  input  logic               clk,
  input  logic               reset_,
  input  logic               test_mode,
  input  logic               sw_rst_req,
  output logic               sw_rst_ack,
  input  logic [NUM_DOM-1:0] dom_idle,
  output logic [NUM_DOM-1:0] dom_reset_,
  output logic               seq_busy,
  output logic               seq_done,
  output logic               qto_flag
);

  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOM - 1);
  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(ASSERT_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(REL_GAP - 1);
  localparam logic [CNT_W-1:0] QTO_TC   = CNT_W'(QTO - 1);

  seq_state_e         state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_DOM-1:0] dom_q;
  logic               ack_q;
  logic               busy_q;
  logic               done_q;
  logic               sw_flag_q;
`ifdef NV_RESET_SEQ_QTO_EN
  logic               qto_q;
`endif

  logic               all_idle;
  logic               cnt_clr;
  logic               cnt_tc;
  logic [CNT_W-1:0]   cnt_tc_val;

  assign all_idle = &dom_idle;

  // Counter is parked at zero whenever it is not timing a phase, so every
  // phase starts counting from a clean zero.
  always_comb begin
    cnt_clr    = 1'b1;
    cnt_tc_val = HOLD_TC;
    case (state_q)
      ST_HOLD: begin
        cnt_tc_val = HOLD_TC;
        cnt_clr    = cnt_tc;
      end
      ST_RELEASE: begin
        cnt_tc_val = GAP_TC;
        cnt_clr    = cnt_tc;
      end
      ST_RUN: begin
        cnt_tc_val = HOLD_TC;
        cnt_clr    = 1'b1;
      end
      ST_QUIESCE: begin
        cnt_tc_val = QTO_TC;
`ifdef NV_RESET_SEQ_QTO_EN
        cnt_clr    = all_idle | cnt_tc;
`else
        cnt_clr    = 1'b1;
`endif
      end
      default: begin
        cnt_tc_val = HOLD_TC;
        cnt_clr    = 1'b1;
      end
    endcase
  end

  nv_reset_seq_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk       (clk),
    .reset_    (reset_),
    .clr_i     (cnt_clr),
    .load_i    (1'b0),
    .load_val_i({CNT_W{1'b0}}),
    .inc_i     (1'b1),
    .tc_val_i  (cnt_tc_val),
    .tc_o      (cnt_tc)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= ST_HOLD;
      idx_q     <= '0;
      dom_q     <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      sw_flag_q <= 1'b0;
`ifdef NV_RESET_SEQ_QTO_EN
      qto_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_tc) begin
            idx_q   <= '0;
            dom_q   <= NUM_DOM'(1);
            state_q <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (cnt_tc) begin
            if (idx_q != LAST_IDX) begin
              idx_q <= idx_q + IDX_W'(1);
              dom_q <= dom_q | (NUM_DOM'(2) << idx_q);
            end else begin
              state_q <= ST_RUN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              if (sw_flag_q) begin
                ack_q     <= 1'b1;
                sw_flag_q <= 1'b0;
              end
            end
          end
        end
        ST_RUN: begin
          if (sw_rst_req && !ack_q) begin
            state_q <= ST_QUIESCE;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
          end else if (ack_q && !sw_rst_req) begin
            ack_q <= 1'b0;
          end
        end
        ST_QUIESCE: begin
          if (all_idle) begin
            dom_q     <= '0;
            sw_flag_q <= 1'b1;
            state_q   <= ST_HOLD;
          end
`ifdef NV_RESET_SEQ_QTO_EN
          else if (cnt_tc) begin
            // Give up waiting for idle; the handshake still completes.
            dom_q     <= '0;
            sw_flag_q <= 1'b1;
            qto_q     <= 1'b1;
            state_q   <= ST_HOLD;
          end
`endif
        end
        default: begin
          state_q <= ST_HOLD;
        end
      endcase
    end
  end

  assign dom_reset_ = test_mode ? {NUM_DOM{reset_}} : dom_q;
  assign sw_rst_ack = ack_q;
  assign seq_busy   = busy_q;
  assign seq_done   = done_q;
`ifdef NV_RESET_SEQ_QTO_EN
  assign qto_flag   = qto_q;
`else
  assign qto_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_nv_reset_seq.sv
// Self-checking bench for nv_reset_seq: timeline-based reference model plus
// directed literal checks and a randomized phase.
module tb_nv_reset_seq;

  localparam int N   = 4;
  localparam int AH  = 8;
  localparam int RG  = 16;
  localparam int QTO = 20;
  localparam int SEQ_LEN = AH + N * RG;

  logic         clk = 1'b0;
  logic         reset_ = 1'b0;
  logic         test_mode = 1'b0;
  logic         sw_rst_req = 1'b0;
  logic [N-1:0] dom_idle = '0;
  logic         sw_rst_ack;
  logic [N-1:0] dom_reset_;
  logic         seq_busy;
  logic         seq_done;
  logic         qto_flag;

  always #5 clk = ~clk;

  nv_reset_seq #(
    .NUM_DOM(N), .CNT_W(8), .ASSERT_HOLD(AH), .REL_GAP(RG), .QTO(QTO)
  ) dut (
    .clk(clk), .reset_(reset_), .test_mode(test_mode),
    .sw_rst_req(sw_rst_req), .sw_rst_ack(sw_rst_ack),
    .dom_idle(dom_idle), .dom_reset_(dom_reset_),
    .seq_busy(seq_busy), .seq_done(seq_done), .qto_flag(qto_flag)
  );

  // Model: mode 0 = sequencing (t edges since sequence start),
  // 1 = running, 2 = quiescing (qt edges since entry).
  int m_mode, m_t, m_qt;
  bit m_ack, m_flag, m_qto;
  int vectors = 0;
  int errors  = 0;

  task automatic m_reset();
    m_mode = 0; m_t = 0; m_qt = 0;
    m_ack = 1'b0; m_flag = 1'b0; m_qto = 1'b0;
  endtask

  function automatic logic [N-1:0] m_dom();
    logic [N-1:0] d;
    d = '1;
    if (m_mode == 0)
      for (int k = 0; k < N; k++) d[k] = (m_t >= AH + k * RG);
    return d;
  endfunction

  task automatic m_edge();
    if (!reset_) begin
      m_reset();
    end else begin
      case (m_mode)
        0: begin
          m_t++;
          if (m_t >= SEQ_LEN) begin
            m_mode = 1;
            if (m_flag) begin m_ack = 1'b1; m_flag = 1'b0; end
          end
        end
        1: begin
          if (sw_rst_req && !m_ack) begin m_mode = 2; m_qt = 0; end
          else if (m_ack && !sw_rst_req) m_ack = 1'b0;
        end
        default: begin
          m_qt++;
          if (&dom_idle) begin
            m_mode = 0; m_t = 0; m_flag = 1'b1;
          end
`ifdef NV_RESET_SEQ_QTO_EN
          else if (m_qt >= QTO) begin
            m_mode = 0; m_t = 0; m_flag = 1'b1; m_qto = 1'b1;
          end
`endif
        end
      endcase
    end
  endtask

  task automatic check(input string name);
    logic [N-1:0] e_dom;
    logic e_busy, e_done;
    e_dom  = test_mode ? {N{reset_}} : m_dom();
    e_busy = (m_mode != 1);
    e_done = (m_mode == 1);
    vectors++;
    if (dom_reset_ !== e_dom || seq_busy !== e_busy || seq_done !== e_done ||
        sw_rst_ack !== m_ack || qto_flag !== m_qto) begin
      errors++;
      $display("FAIL %s t=%0t: got dom=%b busy=%b done=%b ack=%b qto=%b, want dom=%b busy=%b done=%b ack=%b qto=%b",
               name, $time, dom_reset_, seq_busy, seq_done, sw_rst_ack, qto_flag,
               e_dom, e_busy, e_done, m_ack, m_qto);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    @(negedge clk);
    check("model");
  endtask

  initial begin
    m_reset();
    step();
    step();
    lit("rst_dom", 32'(dom_reset_), 32'h0);
    lit("rst_busy", 32'(seq_busy), 32'h1);
    lit("rst_done", 32'(seq_done), 32'h0);
    lit("rst_ack", 32'(sw_rst_ack), 32'h0);
    lit("rst_qto", 32'(qto_flag), 32'h0);

    // Power-up release timeline
    reset_ = 1'b1;
    for (int e = 1; e <= 80; e++) begin
      step();
      if (e == 7)  lit("e7_dom", 32'(dom_reset_), 32'h0);
      if (e == 8)  lit("e8_dom", 32'(dom_reset_), 32'h1);
      if (e == 23) lit("e23_dom", 32'(dom_reset_), 32'h1);
      if (e == 24) lit("e24_dom", 32'(dom_reset_), 32'h3);
      if (e == 40) lit("e40_dom", 32'(dom_reset_), 32'h7);
      if (e == 56) lit("e56_dom", 32'(dom_reset_), 32'hF);
      if (e == 71) lit("e71_done", 32'(seq_done), 32'h0);
      if (e == 72) begin
        lit("e72_done", 32'(seq_done), 32'h1);
        lit("e72_busy", 32'(seq_busy), 32'h0);
      end
    end

    // Soft reset with all domains idle
    dom_idle = 4'hF; sw_rst_req = 1'b1;
    step();
    lit("q_busy", 32'(seq_busy), 32'h1);
    lit("q_dom", 32'(dom_reset_), 32'hF);
    step();
    lit("q_assert", 32'(dom_reset_), 32'h0);
    for (int i = 0; i < SEQ_LEN; i++) step();
    lit("sr_done", 32'(seq_done), 32'h1);
    lit("sr_ack", 32'(sw_rst_ack), 32'h1);
    step();
    lit("sr_ack_hold", 32'(sw_rst_ack), 32'h1);
    sw_rst_req = 1'b0;
    step();
    lit("sr_ack_drop", 32'(sw_rst_ack), 32'h0);

`ifndef NV_RESET_SEQ_QTO_EN
    // Soft reset waits for the last domain to go idle
    dom_idle = 4'b0111; sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    for (int i = 0; i < 50; i++) step();
    lit("wait_dom", 32'(dom_reset_), 32'hF);
    dom_idle = 4'hF;
    step();
    lit("wait_assert", 32'(dom_reset_), 32'h0);
    for (int i = 0; i < SEQ_LEN; i++) step();
    lit("wait_ack", 32'(sw_rst_ack), 32'h1);
    step();
    lit("wait_ack_drop", 32'(sw_rst_ack), 32'h0);
`else
    // Quiesce timeout
    dom_idle = 4'h0; sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    for (int i = 0; i < QTO - 1; i++) step();
    lit("qto_dom_pre", 32'(dom_reset_), 32'hF);
    lit("qto_flag_pre", 32'(qto_flag), 32'h0);
    step();
    lit("qto_dom", 32'(dom_reset_), 32'h0);
    lit("qto_flag", 32'(qto_flag), 32'h1);
    for (int i = 0; i < SEQ_LEN; i++) step();
    lit("qto_done", 32'(seq_done), 32'h1);
    lit("qto_sticky", 32'(qto_flag), 32'h1);
    step();
`endif

    // Async reset in RELEASE with idx=2
    dom_idle = 4'hF;
    #2 reset_ = 1'b0; m_reset();
    #1 check("async0");
    step();
    reset_ = 1'b1;
    for (int i = 0; i < 45; i++) step();
    lit("idx2_dom", 32'(dom_reset_), 32'h7);
    #2 reset_ = 1'b0; m_reset();
    #1 lit("abort_dom", 32'(dom_reset_), 32'h0);
    lit("abort_done", 32'(seq_done), 32'h0);
    lit("abort_busy", 32'(seq_busy), 32'h1);
    step();
    reset_ = 1'b1;
    for (int i = 0; i < 7; i++) step();
    lit("restart_e7", 32'(dom_reset_), 32'h0);
    step();
    lit("restart_e8", 32'(dom_reset_), 32'h1);

    // DFT bypass
    test_mode = 1'b1;
    step();
    #1 reset_ = 1'b0; m_reset();
    #1 lit("tm_fall", 32'(dom_reset_), 32'h0);
    #1 reset_ = 1'b1;
    #1 lit("tm_rise", 32'(dom_reset_), 32'hF);
    for (int i = 0; i < 5; i++) step();
    test_mode = 1'b0;
    #1 lit("tm_off", 32'(dom_reset_), 32'h0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) sw_rst_req = ~sw_rst_req;
      dom_idle  = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom);
      test_mode = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 499) == 0) begin
        reset_ = 1'b0; m_reset();
        #1 check("rand_async");
        step();
        reset_ = 1'b1;
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/nv_reset_seq.md
Name: nv_reset_seq

Overview:
Downstream consumer of the synchronized core reset. It takes the already-synchronized active-low reset and sequences per-domain resets for NUM_DOM sub-domains (e.g. CDMA, CSC, CMAC, SDP), releasing them one at a time in fixed order with programmable gaps. It also handles a software soft-reset request with a four-phase req/ack handshake: quiesce the domains, assert all domain resets, then re-run the release sequence.

Parameters:
NUM_DOM, 4, number of reset domains; minimum 1, maximum 16.
CNT_W, 8, width of the internal delay counter.
ASSERT_HOLD, 8, cycles all domain resets are held low before the first release; range 1..2^CNT_W-1.
REL_GAP, 16, cycles between successive domain releases, and from the last release to seq_done; range 1..2^CNT_W-1.
QTO, 255, quiesce timeout in cycles; used only with the optional feature.

Ports:
clk  in  1  core clock.
reset_  in  1  asynchronous active-low reset; driven by the synchronized reset output.
test_mode  in  1  DFT mode; bypasses sequencing.
sw_rst_req  in  1  software soft-reset request, level, four-phase.
sw_rst_ack  out  1  soft-reset acknowledge.
dom_idle  in  NUM_DOM  per-domain idle indication, active-high.
dom_reset_  out  NUM_DOM  per-domain active-low resets; bit 0 is released first.
seq_busy  out  1  high while in HOLD, RELEASE or QUIESCE.
seq_done  out  1  high only in RUN.
qto_flag  out  1  sticky quiesce-timeout indication.

Behaviour:
- Reset value of every output while reset_=0, asynchronously: dom_reset_=all 0, sw_rst_ack=0, seq_busy=1, seq_done=0, qto_flag=0. State=HOLD, cnt=0, idx=0.
- States: HOLD, RELEASE, RUN, QUIESCE. All outputs are registered, except for the test_mode mux.
- HOLD: cnt increments each edge. On the edge where cnt reaches ASSERT_HOLD-1: cnt<=0, idx<=0, dom_reset_[0]<=1, go to RELEASE. As a result, dom_reset_[0] rises on edge ASSERT_HOLD after reset_ deasserts (edge 1 is the first edge with reset_=1).
- RELEASE: cnt counts REL_GAP edges. At each terminal count:
  - if idx<NUM_DOM-1: idx++, dom_reset_[idx+1]<=1;
  - else: go to RUN, seq_done<=1, seq_busy<=0.
  - Bit k therefore rises on edge ASSERT_HOLD+k*REL_GAP. seq_done rises on edge ASSERT_HOLD+NUM_DOM*REL_GAP.
  - Released bits stay high; release order is strictly ascending.
- RUN: if sw_rst_req=1 and sw_rst_ack=0, go to QUIESCE next edge with seq_done<=0, seq_busy<=1, cnt<=0.
- QUIESCE: dom_reset_ is unchanged. When &dom_idle=1, assert all dom_reset_<=0 on that edge, set sw_flag, and go to HOLD with cnt<=0.
- Soft-reset acknowledge:
  - On entry to RUN with sw_flag set, sw_rst_ack<=1 and sw_flag<=0.
  - In RUN, sw_rst_ack<=0 on the edge after sw_rst_req is sampled low.
  - A new request is accepted only when sw_rst_ack=0.
  - sw_rst_req deasserted during QUIESCE, HOLD or RELEASE is ignored; the sequence completes and ack still pulses high until req is seen low.
- reset_ asserting mid-sequence in any state immediately forces the reset values, aborts the sequence and clears sw_flag.
- test_mode=1: dom_reset_ = {NUM_DOM{reset_}} combinationally; the state machine continues internally. sw_rst_ack and the other outputs remain registered.
- Counter compares use CNT_W bits; no wrap occurs within the legal parameter range.

Optional Feature:
NV_RESET_SEQ_QTO_EN.
- Defined: a QUIESCE counter runs. If &dom_idle has not been seen within QTO cycles, force all dom_reset_ low on the edge the count reaches QTO, set qto_flag<=1, and go to HOLD. qto_flag is cleared only by reset_.
- Undefined: QUIESCE waits indefinitely and qto_flag is tied to 0.

Decomposition:
- Shared header/package nv_reset_seq_pkg:
  - state encodings: HOLD=2'd0, RELEASE=2'd1, RUN=2'd2, QUIESCE=2'd3;
  - default ASSERT_HOLD/REL_GAP/QTO constants.
- One sub-module, nv_reset_seq_cnt: a CNT_W loadable up-counter with clear and terminal-count compare, reused for the hold, gap and timeout counts.

Test Plan:
1. Defaults; reset_ released at edge 0 -> dom_reset_ bits 0..3 rise on edges 8, 24, 40, 56; seq_done rises on edge 72; seq_busy falls on edge 72.
2. In RUN, assert sw_rst_req with dom_idle=4'b1111 -> QUIESCE, all dom_reset_=0 on the next edge, full release sequence, sw_rst_ack=1 at RUN entry; drop req -> ack=0 one edge later.
3. Soft reset with dom_idle=4'b0111 held for 50 cycles -> dom_reset_ stays 4'b1111 until bit 3 goes idle, then all go low on that edge.
4. reset_ pulsed low for 1 cycle while in RELEASE with idx=2 -> dom_reset_=0 asynchronously, seq_done=0, sequence restarts; bit 0 rises 8 edges after reset_ release.
5. test_mode=1 -> dom_reset_ follows reset_ with no delay for both edges, regardless of state.
6. NV_RESET_SEQ_QTO_EN defined, QTO=20, dom_idle=0 -> resets forced low 20 cycles after QUIESCE entry, qto_flag=1 and stays set after the re-sequence.
